// File: rtl/mmio_timer.sv
// mmio_timer: 32-byte MMIO timer (CTRL/COUNT/COMPARE/STATUS/PRESC), one-cycle ack on rd_en_i/wr_en_i hits, prescaled counter with compare match, auto-reload and irq_o
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        irq_o
);
  logic [2:0] ctrl;
  logic [31:0] count, compare, presc, presc_cnt, rdata;
  logic match, hit, acc, wr_acc, wr_count, tick, hw_match;
  logic [2:0] sel;
  logic unused_ok;
  assign unused_ok = ^addr_i[1:0];
  assign hit = addr_i[31:5] == BASE_ADDR[31:5];
  assign acc = hit & (rd_en_i | wr_en_i);
  assign wr_acc = hit & wr_en_i;
  assign sel = addr_i[4:2];
  assign wr_count = wr_acc & (sel == 3'd1);
  assign tick = ctrl[0] & (presc_cnt == presc);
  assign hw_match = tick & ~wr_count & (count == compare);
  assign irq_o = match & ctrl[2];
  always_comb begin
    rdata = sel == 3'd0 ? {29'b0, ctrl} :
            sel == 3'd1 ? count :
            sel == 3'd2 ? compare :
            sel == 3'd3 ? {31'b0, match} :
            sel == 3'd4 ? presc : 32'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl <= '0;
      count <= '0;
      compare <= '0;
      presc <= '0;
      presc_cnt <= '0;
      match <= 1'b0;
      ack_o <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o <= acc;
      data_o <= (acc & ~wr_en_i) ? rdata : 32'b0;
      presc_cnt <= (tick | ~ctrl[0] | (wr_acc & (sel == 3'd4))) ? 32'b0 : presc_cnt + 32'd1;
      if (wr_count) count <= data_i;
      else if (tick) count <= (hw_match & ctrl[1]) ? 32'b0 : count + 32'd1;
      if (hw_match) match <= 1'b1;
      else if (wr_acc & (sel == 3'd3) & data_i[0]) match <= 1'b0;
      if (wr_acc & (sel == 3'd0)) ctrl <= data_i[2:0];
      if (wr_acc & (sel == 3'd2)) compare <= data_i;
      if (wr_acc & (sel == 3'd4)) presc <= data_i;
    end
  end
endmodule
